// File: rtl/pipe_sub_if.sv
// Handshake and data bundle for pipe_sub.
// Macro PIPE_SUB_OVF_EN adds the signed-overflow flag ovfOUT.
// Signals:
//   inValid/inReady     upstream operand handshake
//   operA/operB/Bin     minuend, subtrahend and borrow-in
//   outValid/outReady   downstream result handshake
//   resultOUT/Bout      difference and borrow-out (ovfOUT when enabled)
// Modports: master = the environment driving operands and taking results,
//           slave  = the subtractor.
interface pipe_sub_if #(
    parameter int unsigned N = 16
);
    logic         inValid;
    logic         inReady;
    logic         Bin;
    logic [N-1:0] operA;
    logic [N-1:0] operB;
    logic         outValid;
    logic         outReady;
    logic [N-1:0] resultOUT;
    logic         Bout;
`ifdef PIPE_SUB_OVF_EN
    logic         ovfOUT;
`endif

    modport master (
`ifdef PIPE_SUB_OVF_EN
        input  ovfOUT,
`endif
        output inValid, Bin, operA, operB, outReady,
        input  inReady, outValid, resultOUT, Bout
    );

    modport slave (
`ifdef PIPE_SUB_OVF_EN
        output ovfOUT,
`endif
        input  inValid, Bin, operA, operB, outReady,
        output inReady, outValid, resultOUT, Bout
    );
endinterface

// File: rtl/pipe_sub.sv
// Pipelined unsigned subtractor: resultOUT = (operA - operB - Bin) mod 2^N.
// Each stage resolves CHUNK bits and passes its borrow to the next stage, so
// the latency is STAGES = N/CHUNK cycles at one result per cycle. The whole
// pipeline advances when the output register is empty or being taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pipe_sub_if.slave (operand handshake in, result handshake out)
// Macro PIPE_SUB_OVF_EN adds the registered signed-overflow output ovfOUT.
module pipe_sub #(
    parameter int unsigned N     = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_sub_if.slave bus
);

    localparam int unsigned STAGES = N / CHUNK;
    localparam int unsigned LAST   = STAGES - 1;

    // Configuration sanity: chunks must tile N and there must be at least two stages.
    if ((N % CHUNK) != 0 || STAGES < 2) begin : g_bad_cfg
        $error("pipe_sub: N must be a multiple of CHUNK with N/CHUNK >= 2");
    end

    // Stage state: valid, borrow-out and partially resolved result per stage;
    // full operands ride along in every stage but the last (skew).
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] borrow_q, borrow_d;
    logic [N-1:0]      r_q [STAGES];
    logic [N-1:0]      r_d [STAGES];
    logic [N-1:0]      a_q [LAST];
    logic [N-1:0]      a_d [LAST];
    logic [N-1:0]      b_q [LAST];
    logic [N-1:0]      b_d [LAST];
    logic [CHUNK:0]    slice_c;
    logic              advance_c;
`ifdef PIPE_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // One chunk of A + ~B + ~borrow; returns {borrow_out, difference}.
    function automatic logic [CHUNK:0] sub_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             bin
    );
        logic [CHUNK:0] sum;
        sum = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, ~bin};
        return {~sum[CHUNK], sum[CHUNK-1:0]};
    endfunction

    // Next-state: hold everything on stall, otherwise shift every stage forward.
    always_comb begin
        advance_c = !valid_q[LAST] || bus.outReady;
        valid_d   = valid_q;
        borrow_d  = borrow_q;
        r_d       = r_q;
        a_d       = a_q;
        b_d       = b_q;
        slice_c   = '0;
`ifdef PIPE_SUB_OVF_EN
        ovf_d     = ovf_q;
`endif
        if (advance_c) begin
            // Stage 0: capture operands, or load a bubble when nothing is offered.
            valid_d[0] = bus.inValid;
            if (bus.inValid) begin
                slice_c     = sub_chunk(bus.operA[CHUNK-1:0], bus.operB[CHUNK-1:0], bus.Bin);
                r_d[0]      = {{(N-CHUNK){1'b0}}, slice_c[CHUNK-1:0]};
                borrow_d[0] = slice_c[CHUNK];
                a_d[0]      = bus.operA;
                b_d[0]      = bus.operB;
            end

            // Middle stages: resolve chunk s with the borrow registered by stage s-1.
            for (int s = 1; s < int'(LAST); s++) begin
                slice_c                = sub_chunk(a_q[s-1][s*CHUNK +: CHUNK],
                                                   b_q[s-1][s*CHUNK +: CHUNK],
                                                   borrow_q[s-1]);
                valid_d[s]             = valid_q[s-1];
                r_d[s]                 = r_q[s-1];
                r_d[s][s*CHUNK +: CHUNK] = slice_c[CHUNK-1:0];
                borrow_d[s]            = slice_c[CHUNK];
                a_d[s]                 = a_q[s-1];
                b_d[s]                 = b_q[s-1];
            end

            // Final stage: top chunk completes the result, which is the output register.
            slice_c                        = sub_chunk(a_q[LAST-1][LAST*CHUNK +: CHUNK],
                                                       b_q[LAST-1][LAST*CHUNK +: CHUNK],
                                                       borrow_q[LAST-1]);
            valid_d[LAST]                  = valid_q[LAST-1];
            r_d[LAST]                      = r_q[LAST-1];
            r_d[LAST][LAST*CHUNK +: CHUNK] = slice_c[CHUNK-1:0];
            borrow_d[LAST]                 = slice_c[CHUNK];
`ifdef PIPE_SUB_OVF_EN
            // Operand signs differ and the result sign departs from the minuend's.
            ovf_d = (a_q[LAST-1][N-1] != b_q[LAST-1][N-1]) &&
                    (slice_c[CHUNK-1] != a_q[LAST-1][N-1]);
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            borrow_q <= '0;
            for (int s = 0; s < int'(STAGES); s++) begin
                r_q[s] <= '0;
            end
            for (int s = 0; s < int'(LAST); s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
            end
`ifdef PIPE_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            valid_q  <= valid_d;
            borrow_q <= borrow_d;
            r_q      <= r_d;
            a_q      <= a_d;
            b_q      <= b_d;
`ifdef PIPE_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.inReady   = advance_c;
    assign bus.outValid  = valid_q[LAST];
    assign bus.resultOUT = r_q[LAST];
    assign bus.Bout      = borrow_q[LAST];
`ifdef PIPE_SUB_OVF_EN
    assign bus.ovfOUT    = ovf_q;
`endif

endmodule
